// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAw      = 10;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned DefMaxWait = 4;

  // Which port owns the read result returning from the RAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating fetch wait counter. Counts cycles in which the fetch port is
// requesting but not granted; clears when fetch is granted or stops requesting.
// sat flags that fetch has waited MAX_WAIT cycles and must win the next grant.
module arb_age_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic sat
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WaitMax = MAX_WAIT[CW-1:0];

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // Next count: clear on grant or idle, otherwise count up and stick at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign sat = (wait_cnt_q == WaitMax);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM (1-cycle read latency)
// between the instruction-fetch port and the data port. Data has priority;
// read results are steered back to their issuer one cycle after the grant.
// Optional: define MEM_ARB_AGE_EN to let a starved fetch request win after
// MAX_WAIT cycles of waiting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = DefAw,
  parameter int unsigned DW       = DefDw,
  parameter int unsigned MAX_WAIT = DefMaxWait
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DW/8-1:0]   d_be,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_en,
  output logic [DW/8-1:0]   mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  logic   force_if;
  owner_e rd_own_q, rd_own_d;

`ifdef MEM_ARB_AGE_EN
  logic wait_sat;

  arb_age_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .if_req(if_req),
    .if_gnt(if_gnt),
    .sat   (wait_sat)
  );

  assign force_if = wait_sat & if_req;
`else
  logic [31:0] unused_max_wait;
  assign unused_max_wait = MAX_WAIT;
  assign force_if        = 1'b0;
`endif

  // Grant decision and RAM drive; the RAM sees all zeros when nobody is granted.
  always_comb begin
    d_gnt     = d_req & ~force_if;
    if_gnt    = if_req & ~d_gnt;
    mem_en    = d_gnt | if_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_we) begin
        mem_we = d_be;
      end
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      mem_wdata = d_wdata;
    end
  end

  // Record which port issued this cycle's read so the result can be returned to it.
  always_comb begin
    rd_own_d = OWN_NONE;
    if (d_gnt && !d_we) begin
      rd_own_d = OWN_D;
    end else if (if_gnt) begin
      rd_own_d = OWN_IF;
    end
  end

  // Owner register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_own_q <= OWN_NONE;
    end else begin
      rd_own_q <= rd_own_d;
    end
  end

  assign if_rvalid = (rd_own_q == OWN_IF);
  assign d_rvalid  = (rd_own_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifndef SYNTHESIS
  // Requesters must hold request and address stable until granted.
  a_if_hold : assert property (@(posedge clk) disable iff (!rst)
    (if_req && !if_gnt) |=> (if_req && $stable(if_addr)));
  a_d_hold : assert property (@(posedge clk) disable iff (!rst)
    (d_req && !d_gnt) |=> (d_req && $stable(d_addr) && $stable(d_we)));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// random two-port traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;
`ifdef MEM_ARB_AGE_EN
  localparam bit Aging = 1'b1;
`else
  localparam bit Aging = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h2010_0005;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // RAM the DUT drives: byte-enabled writes, registered reads.
  logic [31:0] ram [1<<AW];
  initial begin : ram_env
    logic          en;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(i);
    forever begin
      @(negedge clk);
      en = mem_en; we = mem_we; a = mem_addr; wd = mem_wdata;
      @(posedge clk);
      if (en) begin
        if (we != 4'b0) begin
          for (int b = 0; b < 4; b++) if (we[b]) ram[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          mem_rdata = ram[a];
        end
      end
    end
  end

  // Reference model: expected grants from priority rules, a queue of reads
  // awaiting return, and a private copy of memory contents.
  typedef struct {
    bit          to_d;
    logic [31:0] data;
  } rd_t;
  rd_t         pend[$];
  logic [31:0] ref_mem [1<<AW];

  initial begin : model
    int            starve;
    logic          f, eg_d, eg_i, c_dwe, c_ireq;
    logic [3:0]    c_be;
    logic [AW-1:0] c_da, c_ia, ea;
    logic [31:0]   c_wd;
    starve = 0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        starve = 0;
      end
      f    = Aging && if_req && (starve == MAX_WAIT);
      eg_d = d_req && !f;
      eg_i = if_req && !eg_d;
      ea   = eg_d ? d_addr : (eg_i ? if_addr : '0);
      chk("m_d_gnt", d_gnt, eg_d);
      chk("m_if_gnt", if_gnt, eg_i);
      chk("m_mem_en", mem_en, eg_d || eg_i);
      chk("m_mem_we", mem_we, (eg_d && d_we) ? d_be : 4'b0);
      chk("m_mem_addr", mem_addr, ea);
      if (eg_d && d_we) chk("m_mem_wdata", mem_wdata, d_wdata);
      if (pend.size() > 0) begin
        chk("m_if_rvalid", if_rvalid, !pend[0].to_d);
        chk("m_d_rvalid", d_rvalid, pend[0].to_d);
        chk("m_rdata", pend[0].to_d ? d_rdata : if_rdata, pend[0].data);
      end else begin
        chk("m_if_rvalid", if_rvalid, 0);
        chk("m_d_rvalid", d_rvalid, 0);
      end
      c_dwe = d_we; c_be = d_be; c_da = d_addr; c_ia = if_addr; c_wd = d_wdata;
      c_ireq = if_req;
      @(posedge clk);
      if (pend.size() > 0) void'(pend.pop_front());
      if (!rst) begin
        starve = 0;
      end else begin
        if (eg_d && !c_dwe) pend.push_back('{1'b1, ref_mem[c_da]});
        if (eg_i) pend.push_back('{1'b0, ref_mem[c_ia]});
        if (c_ireq && !eg_i) starve = (starve < MAX_WAIT) ? starve + 1 : starve;
        else starve = 0;
      end
      if (eg_d && c_dwe) begin
        for (int b = 0; b < 4; b++) if (c_be[b]) ref_mem[c_da][8*b +: 8] = c_wd[8*b +: 8];
      end
    end
  end

  logic gi = 1'b0;
  logic gd = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Keep each pending request until granted, then drop it.
  task automatic release_all();
    for (int i = 0; i < 20 && (if_req || d_req); i++) begin
      @(negedge clk);
      gi = if_gnt; gd = d_gnt;
      step();
      if (gi) if_req = 1'b0;
      if (gd) d_req = 1'b0;
    end
    chk("release_timeout", {30'b0, if_req, d_req}, 0);
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // Fetch alone.
    if_req = 1'b1; if_addr = 10'h004;
    @(negedge clk);
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_d_rvalid_pre", d_rvalid, 0);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'h2010_0005);
    chk("t1_d_rvalid", d_rvalid, 0);

    // Both ports request: data first, fetch next cycle.
    step();
    if_req = 1'b1; if_addr = 10'h008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    @(negedge clk);
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_if_gnt", if_gnt, 0);
    step(); d_req = 1'b0;
    @(negedge clk);
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 32'hA5A5_0010);
    chk("t2_if_gnt2", if_gnt, 1);
    chk("t2_if_rvalid_early", if_rvalid, 0);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, 32'hA5A5_0008);
    chk("t2_d_rvalid_late", d_rvalid, 0);

    // Partial write then read back.
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    @(negedge clk);
    chk("t3_wr_gnt", d_gnt, 1);
    chk("t3_mem_we", mem_we, 4'b0011);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); d_we = 1'b0; d_be = 4'b0;
    @(negedge clk);
    chk("t3_rd_gnt", d_gnt, 1);
    chk("t3_wr_no_rvalid", d_rvalid, 0);
    step(); d_req = 1'b0;
    @(negedge clk);
    chk("t3_d_rvalid", d_rvalid, 1);
    chk("t3_d_rdata", d_rdata, 32'hA5A5_BEEF);
    step();
    @(negedge clk);
    chk("t3_d_rvalid_once", d_rvalid, 0);

    // Data hogs the RAM while fetch waits.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030;
    if_req = 1'b1; if_addr = 10'h040;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t4_if_gnt", if_gnt, Aging && (k == 5 || k == 10));
      chk("t4_d_gnt", d_gnt, !(Aging && (k == 5 || k == 10)));
      gi = if_gnt; gd = d_gnt;
      step();
    end
    if (gd) d_req = 1'b0;
    if (gi) if_req = 1'b0;
    release_all();

    // Reset with a fetch read in flight.
    step();
    if_req = 1'b1; if_addr = 10'h004;
    @(negedge clk);
    chk("t5_if_gnt", if_gnt, 1);
    step(); if_req = 1'b0;
    chk("t5_rvalid_pre", if_rvalid, 1);
    #1 rst = 1'b0;
    #1 chk("t5_rvalid_rst", if_rvalid, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t5_if_rvalid_post", if_rvalid, 0);
    chk("t5_d_rvalid_post", d_rvalid, 0);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    @(negedge clk);
    chk("t5_d_gnt", d_gnt, 1);
    step(); d_req = 1'b0;
    @(negedge clk);
    chk("t5_d_rvalid", d_rvalid, 1);
    chk("t5_d_rdata", d_rdata, 32'hA5A5_BEEF);

    // Random traffic on both ports; the model checks every cycle.
    step();
    gi = 1'b0; gd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(if_req && !gi)) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 10'($urandom_range(0, 63));
      end
      if (!(d_req && !gd)) begin
        d_req   = ($urandom_range(0, 99) < 50);
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_addr  = 10'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
      @(negedge clk);
      gi = if_gnt; gd = d_gnt;
      step();
    end
    if (gi) if_req = 1'b0;
    if (gd) d_req = 1'b0;
    release_all();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
